// File: rtl/mc_controller.sv
// rtl/mc_controller.sv - multi-cycle instruction controller FSM
//
// Purpose: sequences FETCH/DECODE/EXEC/MEM/WB for a single-issue core.
// It decodes the latched instruction register into datapath selects and
// register addresses. Data-memory accesses that never complete are aborted
// with a sticky mem_error flag.
// Optional feature: define PERF_CNT_EN to add cycle_count/retire_count.
//
// Ports:
//   clock, reset                         clock, async active-low reset
//   ir, IM_ready, DM_ready               instruction word, memory handshakes
//   enable_pc, IM_enable, DM_enable,     PC and memory strobes
//   DM_read, DM_write
//   do_reg_fetch, enable_execute,        datapath phase strobes
//   do_reg_write
//   imm_reg_select, mux4to1_select,      datapath selects
//   write_reg_select
//   opcode, read_address1/2,             fields of the latched instruction
//   write_address, imm_5bit
//   state, mem_error                     current state, sticky timeout flag
//   cycle_count, retire_count            performance counters (PERF_CNT_EN)
//
// Opcode map (ir[30:25], hex):
//   NOP 00, ADD 01, SUB 02, AND 03, OR 04, XOR 05, SRLI 06, SLLI 07,
//   ROTRI 08, ADDI 09, ORI 0A, XORI 0B, MOVI 0C, LWI 0D, SWI 0E, LW 0F, SW 10.
//   Every other code behaves as a no-op.
module mc_controller #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] ir,
  input  logic        IM_ready,
  input  logic        DM_ready,
  output logic        enable_pc,
  output logic        IM_enable,
  output logic        DM_enable,
  output logic        DM_read,
  output logic        DM_write,
  output logic        do_reg_fetch,
  output logic        enable_execute,
  output logic        do_reg_write,
  output logic [1:0]  imm_reg_select,
  output logic [1:0]  mux4to1_select,
  output logic [1:0]  write_reg_select,
  output logic [5:0]  opcode,
  output logic [4:0]  read_address1,
  output logic [4:0]  read_address2,
  output logic [4:0]  write_address,
  output logic [4:0]  imm_5bit,
  output logic [2:0]  state,
  output logic        mem_error
`ifdef PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] retire_count
`endif
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  localparam logic [5:0] OP_ADD   = 6'h01;
  localparam logic [5:0] OP_SUB   = 6'h02;
  localparam logic [5:0] OP_AND   = 6'h03;
  localparam logic [5:0] OP_OR    = 6'h04;
  localparam logic [5:0] OP_XOR   = 6'h05;
  localparam logic [5:0] OP_SRLI  = 6'h06;
  localparam logic [5:0] OP_SLLI  = 6'h07;
  localparam logic [5:0] OP_ROTRI = 6'h08;
  localparam logic [5:0] OP_ADDI  = 6'h09;
  localparam logic [5:0] OP_ORI   = 6'h0A;
  localparam logic [5:0] OP_XORI  = 6'h0B;
  localparam logic [5:0] OP_MOVI  = 6'h0C;
  localparam logic [5:0] OP_LWI   = 6'h0D;
  localparam logic [5:0] OP_SWI   = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h0F;
  localparam logic [5:0] OP_SW    = 6'h10;

  // Wait-counter value of the last MEM cycle allowed before abort.
  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t      cur;
  logic [31:0] instr;
  logic [7:0]  wait_cnt;
  logic        is_wb_op;
  logic        is_load;
  logic        is_store;

  assign state         = cur;
  assign opcode        = instr[30:25];
  assign write_address = instr[24:20];
  assign read_address1 = instr[19:15];
  assign read_address2 = instr[14:10];
  assign imm_5bit      = instr[14:10];

  // Bits outside the decoded fields are carried in the register but unused.
  logic unused_bits;
  assign unused_bits = ^{instr[31], instr[9:0]};

  // The PC advances in the very cycle the fetch completes, so this strobe
  // is the one output that follows IM_ready combinationally.
  assign enable_pc = (cur == S_FETCH) && IM_enable && IM_ready;

  always_comb begin
    imm_reg_select   = 2'b00;
    mux4to1_select   = 2'b00;
    write_reg_select = 2'b00;
    is_wb_op         = 1'b0;
    is_load          = 1'b0;
    is_store         = 1'b0;
    case (opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: is_wb_op = 1'b1;
      OP_SRLI, OP_SLLI, OP_ROTRI: begin
        is_wb_op       = 1'b1;
        imm_reg_select = 2'b01;
      end
      OP_ADDI: begin
        is_wb_op       = 1'b1;
        imm_reg_select = 2'b01;
        mux4to1_select = 2'b01;
      end
      OP_ORI, OP_XORI: begin
        is_wb_op       = 1'b1;
        imm_reg_select = 2'b01;
        mux4to1_select = 2'b10;
      end
      OP_MOVI: begin
        is_wb_op         = 1'b1;
        imm_reg_select   = 2'b01;
        mux4to1_select   = 2'b11;
        write_reg_select = 2'b01;
      end
      OP_LWI: begin
        is_load          = 1'b1;
        imm_reg_select   = 2'b10;
        write_reg_select = 2'b10;
      end
      OP_SWI: begin
        is_store       = 1'b1;
        imm_reg_select = 2'b10;
      end
      OP_LW: begin
        is_load          = 1'b1;
        imm_reg_select   = 2'b11;
        write_reg_select = 2'b10;
      end
      OP_SW: begin
        is_store       = 1'b1;
        imm_reg_select = 2'b11;
      end
      default: ;
    endcase
  end

  // Strobes are registered alongside the state: every transition raises the
  // strobes of the state being entered. After reset the FSM sits in FETCH
  // with IM_enable low; the first clock opens the fetch.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cur            <= S_FETCH;
      instr          <= '0;
      wait_cnt       <= '0;
      mem_error      <= 1'b0;
      IM_enable      <= 1'b0;
      DM_enable      <= 1'b0;
      DM_read        <= 1'b0;
      DM_write       <= 1'b0;
      do_reg_fetch   <= 1'b0;
      enable_execute <= 1'b0;
      do_reg_write   <= 1'b0;
    end else begin
      IM_enable      <= 1'b0;
      DM_enable      <= 1'b0;
      DM_read        <= 1'b0;
      DM_write       <= 1'b0;
      do_reg_fetch   <= 1'b0;
      enable_execute <= 1'b0;
      do_reg_write   <= 1'b0;
      case (cur)
        S_FETCH: begin
          if (IM_enable && IM_ready) begin
            instr        <= ir;
            cur          <= S_DECODE;
            do_reg_fetch <= 1'b1;
          end else begin
            IM_enable <= 1'b1;
          end
        end
        S_DECODE: begin
          cur            <= S_EXEC;
          enable_execute <= 1'b1;
        end
        S_EXEC: begin
          if (is_load || is_store) begin
            cur       <= S_MEM;
            DM_enable <= 1'b1;
            DM_read   <= is_load;
            DM_write  <= is_store;
            wait_cnt  <= '0;
          end else if (is_wb_op) begin
            cur          <= S_WB;
            do_reg_write <= 1'b1;
          end else begin
            cur       <= S_FETCH;
            IM_enable <= 1'b1;
          end
        end
        S_MEM: begin
          // A DM_ready arriving in the last allowed cycle still completes.
          if (DM_ready) begin
            if (is_load) begin
              cur          <= S_WB;
              do_reg_write <= 1'b1;
            end else begin
              cur       <= S_FETCH;
              IM_enable <= 1'b1;
            end
          end else if (wait_cnt == WAIT_LAST) begin
            mem_error <= 1'b1;
            cur       <= S_FETCH;
            IM_enable <= 1'b1;
          end else begin
            wait_cnt  <= wait_cnt + 8'd1;
            DM_enable <= 1'b1;
            DM_read   <= is_load;
            DM_write  <= is_store;
          end
        end
        S_WB: begin
          cur       <= S_FETCH;
          IM_enable <= 1'b1;
        end
        default: begin
          cur       <= S_FETCH;
          IM_enable <= 1'b1;
        end
      endcase
    end
  end

`ifdef PERF_CNT_EN
  // An instruction retires when the FSM returns to FETCH through its normal
  // path; a MEM timeout returns without retiring.
  logic retire;
  assign retire = (cur == S_WB) ||
                  ((cur == S_EXEC) && !is_load && !is_store && !is_wb_op) ||
                  ((cur == S_MEM) && DM_ready && is_store);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cycle_count  <= '0;
      retire_count <= '0;
    end else begin
      cycle_count <= cycle_count + CNT_W'(1);
      if (retire) retire_count <= retire_count + CNT_W'(1);
    end
  end
`else
  logic [CNT_W-1:0] unused_cnt;
  assign unused_cnt = '0;
`endif

endmodule

// File: tb/tb_mc_controller.sv
// tb/tb_mc_controller.sv - randomized scoreboard bench for mc_controller
module tb_mc_controller;
  localparam int TO      = 15;
  localparam int CW      = 4;
  localparam int NEVER   = 1000;
  localparam int N_INSTR = 60;
  localparam int LIMIT   = 6000;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] ir;
  logic        IM_ready;
  logic        DM_ready;
  logic        enable_pc;
  logic        IM_enable;
  logic        DM_enable;
  logic        DM_read;
  logic        DM_write;
  logic        do_reg_fetch;
  logic        enable_execute;
  logic        do_reg_write;
  logic [1:0]  imm_reg_select;
  logic [1:0]  mux4to1_select;
  logic [1:0]  write_reg_select;
  logic [5:0]  opcode;
  logic [4:0]  read_address1;
  logic [4:0]  read_address2;
  logic [4:0]  write_address;
  logic [4:0]  imm_5bit;
  logic [2:0]  state;
  logic        mem_error;
`ifdef PERF_CNT_EN
  logic [CW-1:0] cycle_count;
  logic [CW-1:0] retire_count;
`endif

  always #5 clock = ~clock;

  mc_controller #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clock(clock), .reset(reset), .ir(ir),
    .IM_ready(IM_ready), .DM_ready(DM_ready),
    .enable_pc(enable_pc), .IM_enable(IM_enable), .DM_enable(DM_enable),
    .DM_read(DM_read), .DM_write(DM_write),
    .do_reg_fetch(do_reg_fetch), .enable_execute(enable_execute),
    .do_reg_write(do_reg_write),
    .imm_reg_select(imm_reg_select), .mux4to1_select(mux4to1_select),
    .write_reg_select(write_reg_select), .opcode(opcode),
    .read_address1(read_address1), .read_address2(read_address2),
    .write_address(write_address), .imm_5bit(imm_5bit),
    .state(state), .mem_error(mem_error)
`ifdef PERF_CNT_EN
    , .cycle_count(cycle_count), .retire_count(retire_count)
`endif
  );

  logic [7:0]  strobes_vec;
  logic [31:0] decode_vec;
  assign strobes_vec = {enable_pc, IM_enable, DM_enable, DM_read, DM_write,
                        do_reg_fetch, enable_execute, do_reg_write};
  assign decode_vec  = {opcode, write_address, read_address1, read_address2,
                        imm_5bit, imm_reg_select, mux4to1_select, write_reg_select};

  // cls: 0 = no-op, 1 = register write, 2 = load, 3 = store
  typedef struct {
    logic [5:0] op;
    logic [4:0] wa;
    logic [4:0] ra1;
    logic [4:0] ra2;
    logic [5:0] sel;
    int         cls;
    int         d;
    int         imd;
  } rec_t;

  rec_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  bit   busy = 0;
  bit   mon_on = 0;
  bit   abort_mon = 0;
  int   model_err = 0;
  int   model_ret = 0;
  int   tb_cycles = 0;

  always @(posedge clock or negedge reset)
    if (!reset) tb_cycles <= 0;
    else        tb_cycles <= tb_cycles + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic void classify(input logic [5:0] op, output int cls, output logic [5:0] sel);
    cls = 0;
    sel = 6'b00_00_00;
    case (op)
      6'h01, 6'h02, 6'h03, 6'h04, 6'h05: cls = 1;
      6'h06, 6'h07, 6'h08: begin cls = 1; sel = 6'b01_00_00; end
      6'h09:               begin cls = 1; sel = 6'b01_01_00; end
      6'h0A, 6'h0B:        begin cls = 1; sel = 6'b01_10_00; end
      6'h0C:               begin cls = 1; sel = 6'b01_11_01; end
      6'h0D:               begin cls = 2; sel = 6'b10_00_10; end
      6'h0E:               begin cls = 3; sel = 6'b10_00_00; end
      6'h0F:               begin cls = 2; sel = 6'b11_00_10; end
      6'h10:               begin cls = 3; sel = 6'b11_00_00; end
      default: ;
    endcase
  endfunction

  function automatic bit timed_out(input rec_t r);
    return (r.cls >= 2) && (r.d + 1 > TO);
  endfunction

  function automatic int mem_cycles(input rec_t r);
    return (r.d + 1 > TO) ? TO : r.d + 1;
  endfunction

  function automatic int exp_len(input rec_t r);
    case (r.cls)
      1: return 3;
      2: return 2 + mem_cycles(r) + (timed_out(r) ? 0 : 1);
      3: return 2 + mem_cycles(r);
      default: return 2;
    endcase
  endfunction

  function automatic int exp_state(input rec_t r, input int j);
    if (j > exp_len(r)) return 0;
    if (j == 1) return 1;
    if (j == 2) return 2;
    if (r.cls == 1) return 4;
    if (j <= 2 + mem_cycles(r)) return 3;
    return 4;
  endfunction

  function automatic logic [7:0] exp_strobes(input int es, input int cls, input logic pc, input logic im);
    case (es)
      0: return {pc, im, 6'b000000};
      1: return 8'b0000_0100;
      2: return 8'b0000_0010;
      3: return {3'b001, 1'(cls == 2), 1'(cls == 3), 3'b000};
      4: return 8'b0000_0001;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic rec_t next_rec(input int idx);
    rec_t r;
    int   k;
    int   dtab[8] = '{0, 0, 1, 2, 3, 14, 15, NEVER};
    r.d = 0;
    r.imd = 0;
    case (idx)
      0: r.op = 6'h01;
      1: begin r.op = 6'h0F; r.d = 3; end
      2: begin r.op = 6'h10; r.d = NEVER; end
      3: begin r.op = 6'h0C; r.imd = 1; end
      4: r.op = 6'h00;
      5: begin r.op = 6'h0D; r.d = 14; end
      6: begin r.op = 6'h0E; r.d = 15; end
      default: begin
        k = $urandom_range(0, 19);
        r.op = (k <= 16) ? 6'(k) : 6'($urandom_range(17, 63));
        r.d = dtab[$urandom_range(0, 7)];
        r.imd = $urandom_range(0, 2);
      end
    endcase
    r.wa  = 5'($urandom);
    r.ra1 = 5'($urandom);
    r.ra2 = 5'($urandom);
    classify(r.op, r.cls, r.sel);
    return r;
  endfunction

  // Monitor: pops an expected record on each completed fetch and follows
  // that instruction until the controller returns to FETCH.
  initial begin
    rec_t cur;
    int   j;
    int   es;
    bit   first;
    first = 1;
    j = 0;
    forever begin
      @(negedge clock);
      #2;
      if (!mon_on || abort_mon || !reset) continue;
      if (busy) begin
        if (state == 3'd0) begin
          busy = 0;
          chk("busy_len", j, exp_len(cur));
          if (timed_out(cur)) model_err = 1;
          else model_ret++;
          chk("mem_error", mem_error, model_err);
`ifdef PERF_CNT_EN
          chk("retire_count", retire_count, model_ret % (1 << CW));
          chk("cycle_count", cycle_count, tb_cycles % (1 << CW));
`endif
        end else begin
          j++;
          es = exp_state(cur, j);
          chk("state", state, es);
          chk("strobes", strobes_vec, exp_strobes(es, cur.cls, 1'b0, 1'b0));
          chk("decode", decode_vec, {cur.op, cur.wa, cur.ra1, cur.ra2, cur.ra2, cur.sel});
          if (j > 40) busy = 0;
        end
      end
      if (!busy && state == 3'd0) begin
        chk("fetch_strobes", strobes_vec, exp_strobes(0, 0, !first && IM_ready, !first));
        first = 0;
        if (enable_pc) begin
          chk("fetch_queue", exp_q.size(), 1);
          if (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            busy = 1;
            j = 0;
          end
        end
      end
    end
  end

  // Driver: supplies instructions and memory handshakes with random delays
  // and random noise on inputs that must be ignored.
  initial begin
    rec_t r;
    int   fw;
    int   mw;
    int   cur_d;
    int   issued;
    bit   got;
    reset = 1'b0;
    ir = '0;
    IM_ready = 1'b0;
    DM_ready = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_state", state, 3'd0);
    chk("rst_strobes", strobes_vec, 8'h00);
    chk("rst_mem_error", mem_error, 1'b0);
    chk("rst_decode", decode_vec, 32'h0);
`ifdef PERF_CNT_EN
    chk("rst_counters", {cycle_count, retire_count}, '0);
`endif
    reset = 1'b1;
    mon_on = 1;
    fw = 0;
    mw = 0;
    cur_d = 0;
    issued = 0;
    r = next_rec(0);
    for (int cyc = 0; cyc < LIMIT; cyc++) begin
      @(negedge clock);
      if (issued == N_INSTR && !busy && exp_q.size() == 0) break;
      if (IM_enable) begin
        DM_ready = 1'($urandom);
        if (issued < N_INSTR && fw >= r.imd) begin
          ir = {1'($urandom), r.op, r.wa, r.ra1, r.ra2, 10'($urandom)};
          IM_ready = 1'b1;
          exp_q.push_back(r);
          issued++;
          cur_d = r.d;
          mw = 0;
          fw = 0;
          r = next_rec(issued);
        end else begin
          ir = $urandom;
          IM_ready = 1'b0;
          fw++;
        end
      end else if (DM_enable) begin
        DM_ready = (mw >= cur_d);
        mw++;
        IM_ready = 1'($urandom);
        ir = $urandom;
      end else begin
        IM_ready = 1'($urandom);
        DM_ready = 1'($urandom);
        ir = $urandom;
      end
    end
    chk("run_complete", (issued == N_INSTR) && !busy && (exp_q.size() == 0), 1'b1);

    // Reset asserted while a store is waiting in MEM.
    chk("mem_error_sticky", mem_error, model_err);
    abort_mon = 1;
    got = 0;
    for (int c = 0; c < 30 && !got; c++) begin
      @(negedge clock);
      DM_ready = 1'b0;
      if (IM_enable) begin
        ir = {1'b0, 6'h10, 5'd1, 5'd2, 5'd3, 10'd0};
        IM_ready = 1'b1;
        got = 1;
      end else begin
        IM_ready = 1'b0;
      end
    end
    got = 0;
    for (int c = 0; c < 30 && !got; c++) begin
      @(negedge clock);
      IM_ready = 1'b0;
      DM_ready = 1'b0;
      if (DM_write) got = 1;
    end
    chk("sw_reached_mem", got, 1'b1);
    @(posedge clock);
    #3;
    reset = 1'b0;
    #1;
    chk("rst_mid_mem_write", {DM_enable, DM_write}, 2'b00);
    chk("rst_mid_mem_state", state, 3'd0);
    chk("rst_mid_mem_error", mem_error, 1'b0);
    chk("rst_mid_mem_strobes", strobes_vec, 8'h00);
`ifdef PERF_CNT_EN
    chk("rst_mid_mem_counters", {cycle_count, retire_count}, '0);
`endif
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("idle_before_first_edge", {state, IM_enable}, {3'd0, 1'b0});
    @(posedge clock);
    #1;
    chk("first_fetch", {state, IM_enable}, {3'd0, 1'b1});
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

endmodule

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 15, max cycles waiting for DM_ready before abort (range 1..255).
REQ-002 SHALL have parameter CNT_W, default 32, width of performance counters.
REQ-003 SHALL have port clock  in  1  single clock, all flops on rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port ir  in  32  instruction word from instruction memory.
REQ-006 SHALL have ports IM_ready / DM_ready  in  1 each  memory access complete, sampled each cycle.
REQ-007 SHALL have ports enable_pc, IM_enable, DM_enable, DM_read, DM_write  out  1 each  PC and memory strobes.
REQ-008 SHALL have ports do_reg_fetch, enable_execute, do_reg_write  out  1 each  datapath phase strobes.
REQ-009 SHALL have ports imm_reg_select, mux4to1_select, write_reg_select  out  2 each  datapath selects.
REQ-010 SHALL have ports opcode  out  6, and read_address1, read_address2, write_address, imm_5bit  out  5 each.
REQ-011 SHALL have ports state  out  3 (current state) and mem_error  out  1 (sticky timeout flag).
REQ-012 SHALL have ports cycle_count, retire_count  out  CNT_W each (present only under PERF_CNT_EN).

Function
REQ-013 SHALL implement states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4; codes 5-7 go to FETCH next cycle with all strobes low.
REQ-014 FETCH: IM_enable=1; stay until IM_ready=1; on IM_ready capture ir into instruction register, pulse enable_pc for that cycle, go DECODE.
REQ-015 DECODE: do_reg_fetch=1 for one cycle; go EXEC.
REQ-016 EXEC: enable_execute=1 for one cycle; next = MEM for LWI/SWI/LW/SW, WB for register-writing ops, FETCH otherwise (NOP, unknown).
REQ-017 MEM: DM_enable=1 with DM_read (loads) or DM_write (stores); on DM_ready next = WB (load) or FETCH (store).
REQ-018 MEM timeout: wait counter counts from entry; if DM_ready not seen after MEM_TIMEOUT cycles, set mem_error, go FETCH without WB.
REQ-019 WB: do_reg_write=1 for one cycle; go FETCH.
REQ-020 All decode outputs SHALL derive from latched instruction register, never live ir; fields as def_op.v: opcode [30:25], write_address [24:20], read_address1 [19:15], read_address2/imm_5bit [14:10].
REQ-021 Selects SHALL follow def_op.v decode: register ALU ops imm/mux/write = 00/00/00; SRLI/SLLI/ROTRI 01/00/00; ADDI 01/01/00; ORI/XORI 01/10/00; MOVI 01/11/01; LWI 10/--/10; SWI 10; LW 11/--/10; SW 11; others 00/00/00; don't-care values driven 00.
REQ-022 Latency (zero-wait memory): ALU 4 cycles, load 5, store 4, NOP 3 per instruction.
REQ-023 IM_ready/DM_ready asserted outside FETCH/MEM SHALL be ignored.
REQ-024 mem_error SHALL clear only on reset.

Reset
REQ-025 Reset low SHALL immediately force state=FETCH, instruction register=0, wait counter=0, mem_error=0, counters=0, all strobes 0, selects 00.
REQ-026 Reset mid-MEM SHALL drop DM_enable/DM_write combinationally-from-reset (no partial write strobe after reset edge).
REQ-027 First FETCH SHALL begin on first rising clock after reset deasserts.

Configuration
REQ-028 Macro PERF_CNT_EN defined: cycle_count increments every non-reset cycle, retire_count increments on each FETCH entry from EXEC/MEM/WB (not from timeout); both wrap at 2^CNT_W.
REQ-029 Macro PERF_CNT_EN undefined: counter ports and logic absent; all other behaviour identical.

Verification
REQ-030 ADD with IM_ready/DM_ready tied 1 -> states 0,1,2,4,0; do_reg_write one cycle; selects 00/00/00; retire_count=1 after 4 cycles.
REQ-031 LW with DM_ready delayed 3 cycles -> MEM held 4 cycles with DM_read=1, then WB; write_reg_select=10, imm_reg_select=11.
REQ-032 SW with DM_ready never asserted, MEM_TIMEOUT=15 -> mem_error=1 after 15 MEM cycles, next state FETCH, no do_reg_write.
REQ-033 ir changes during DECODE/EXEC -> outputs unchanged (latched MOVI still gives 01/11/01).
REQ-034 Reset low asserted in MEM during SW -> DM_write=0 same cycle, state=0, counters=0.
REQ-035 PERF_CNT_EN with CNT_W=4, 20 NOPs -> retire_count wraps to 4, cycle_count wraps correctly.
